imem_boot_ctrl: RTL

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Loads a program image from a byte stream into instruction memory and
//   releases the core once the image is complete.
//   Stream format: one header byte holding the word count N, then 4*N data
//   bytes (little-endian words). When IMEM_BOOT_CHECKSUM_EN is defined, a
//   trailing byte follows that must equal the XOR of all data bytes.
//
// Build option:
//   IMEM_BOOT_CHECKSUM_EN  adds the checksum state and its accumulator.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       single-cycle request to begin a load session
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    byte accepted this cycle when in_valid is also high
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_waddr  word address for imem_we (held between writes)
//   imem_wdata  word data for imem_we (held between writes)
//   cpu_run     program loaded; releases the core from hold
//   busy        load session in progress
//   load_err    last session failed; held until next start or reset
module imem_boot_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          load_err
);

  if ((2 ** AW) != DEPTH) begin : g_depth_check
    $error("imem_boot_ctrl: DEPTH must equal 2**AW");
  end

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;      // word count N from the header
  logic [1:0]      byte_q, byte_d;    // byte position within current word
  logic [7:0]      widx_q, widx_d;    // index of the word being assembled
  logic [23:0]     asm_q, asm_d;      // first three bytes of current word
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            run_q, run_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic accept;
  logic last_word;

  always_comb begin
    in_ready = (state_q == ST_HDR) || (state_q == ST_DATA)
`ifdef IMEM_BOOT_CHECKSUM_EN
               || (state_q == ST_CSUM)
`endif
               ;
  end

  assign busy     = in_ready;
  assign load_err = (state_q == ST_ERR);
  assign cpu_run  = run_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

  assign accept    = in_valid && in_ready;
  assign last_word = ((widx_q + 8'd1) == cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    widx_d  = widx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          byte_d  = '0;
          widx_d  = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_HDR: begin
        if (accept) begin
          cnt_d = in_data;
          if (in_data == 8'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else if ({24'd0, in_data} > DEPTH_U) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_d = byte_q + 2'd1;
          case (byte_q)
            2'd0:    asm_d[7:0]   = in_data;
            2'd1:    asm_d[15:8]  = in_data;
            2'd2:    asm_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              waddr_d = AW'(widx_q);
              wdata_d = {in_data, asm_q};
              widx_d  = widx_q + 8'd1;
              if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state_d = ST_CSUM;
`else
                state_d = ST_DONE;
`endif
              end
            end
          endcase
        end
      end

`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // cpu_run is held off while the final write strobe is still on the
    // bus, so it rises the cycle after that strobe.
    run_d = (state_d == ST_DONE) && !we_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      widx_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      widx_q  <= widx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
